// File: rtl/dmem_unit_if.sv
// dmem_unit_if: M-stage to data-memory request/response bundle.
`default_nettype none

interface dmem_unit_if;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_data;
  logic [63:0] m_valM;
  logic        dmem_error;
  logic        mem_stall;
  logic        mem_done;

  modport master (
    output mem_read, mem_write, mem_addr, mem_data,
    input  m_valM, dmem_error, mem_stall, mem_done
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_data,
    output m_valM, dmem_error, mem_stall, mem_done
  );
endinterface

`default_nettype wire

// File: rtl/dmem_unit.sv
// ============================================================================
// Module   : dmem_unit
// Brief    : Y86 data memory, byte-addressed little-endian RAM with
//            configurable latency, bounds checking and pipeline stall.
//            Optional macro DMEM_ALIGN_CHECK_EN rejects unaligned accesses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_unit #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY     = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_unit_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [3:0]      cnt, cnt_nx;
  logic [63:0]     val_q;
  logic [63:0]     rd_word;
  logic [7:0]      ram [DEPTH_BYTES];
  logic [AW-1:0]   base;
  logic            req, bad, ok, misalign;
  logic            stall, done, commit;

`ifdef DMEM_ALIGN_CHECK_EN
  assign misalign = |bus.mem_addr[2:0];
`else
  assign misalign = 1'b0;
`endif

  // Gating with rst_n keeps every output at its reset value while reset is held.
  assign req  = (bus.mem_read | bus.mem_write) & rst_n;
  assign bad  = (bus.mem_addr > 64'(DEPTH_BYTES - 8))
              | (bus.mem_read & bus.mem_write)
              | misalign;
  assign ok   = req & ~bad;
  assign base = bus.mem_addr[AW-1:0];

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      rd_word[8*i +: 8] = ram[base + AW'(i)];
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    done     = 1'b0;
    commit   = 1'b0;
    case (state)
      S_IDLE: begin
        if (ok) begin
          if (LATENCY == 1) begin
            done   = 1'b1;
            commit = 1'b1;
          end else if (LATENCY == 2) begin
            stall    = 1'b1;
            commit   = 1'b1;
            state_nx = S_LAST;
          end else begin
            stall    = 1'b1;
            cnt_nx   = 4'(LATENCY - 2);
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!ok) begin
          // Request withdrawn by a bubble/flush: abandon without committing.
          cnt_nx   = '0;
          state_nx = S_IDLE;
        end else begin
          stall  = 1'b1;
          cnt_nx = cnt - 4'd1;
          if (cnt == 4'd1) begin
            commit   = 1'b1;
            state_nx = S_LAST;
          end
        end
      end
      S_LAST: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      val_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (commit && bus.mem_read) begin
        val_q <= rd_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && bus.mem_write) begin
      for (int i = 0; i < 8; i++) begin
        ram[base + AW'(i)] <= bus.mem_data[8*i +: 8];
      end
    end
  end

  generate
    if (LATENCY == 1) begin : g_lat1
      assign bus.m_valM = (ok && bus.mem_read) ? rd_word : val_q;
    end else begin : g_latn
      assign bus.m_valM = val_q;
    end
  endgenerate

  assign bus.dmem_error = req & bad;
  assign bus.mem_stall  = stall;
  assign bus.mem_done   = done;

endmodule

`default_nettype wire

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: scoreboard bench for dmem_unit (LATENCY=3 main instance, LATENCY=1 side instance).
`default_nettype none

module tb_dmem_unit;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  localparam logic [63:0] D1 = 64'h1122334455667788;
  localparam logic [63:0] D2 = 64'hA5A5_0102_0304_5A5A;
  localparam logic [63:0] D3 = 64'hCAFE_F00D_DEAD_BEEF;
  localparam logic [63:0] D4 = 64'h0F1E_2D3C_4B5A_6978;

  logic clk = 1'b0;
  logic rst_n;

  dmem_unit_if bus ();
  dmem_unit_if bus1 ();

  dmem_unit #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dmem_unit #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0]  mdl [DEPTH];
  logic [63:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [63:0] addr);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mdl[int'(addr) + i];
    return w;
  endfunction

  task automatic model_wr(input logic [63:0] addr, input logic [63:0] data);
    for (int i = 0; i < 8; i++) mdl[int'(addr) + i] = data[8*i +: 8];
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
    bus.mem_read  = rd;
    bus.mem_write = wr;
    bus.mem_addr  = addr;
    bus.mem_data  = data;
  endtask

  // Called at a negedge; returns at the negedge following the completion cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
    int cyc;
    bit fin;
    logic [63:0] e;
    drive(rd, wr, addr, data);
    if (rd) exp_q.push_back(model_rd(addr));
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 20) begin
      #1;
      cyc++;
      if (bus.mem_done) begin
        check("done_latency", 64'(cyc), 64'(LAT));
        check("done_nostall", 64'(bus.mem_stall), 64'd0);
        if (rd) begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hX;
          check("load_data", bus.m_valM, e);
        end else begin
          model_wr(addr, data);
        end
        fin = 1;
      end else begin
        check("stall_active", 64'(bus.mem_stall), 64'd1);
      end
      @(negedge clk);
    end
    if (!fin) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic go_idle();
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
  endtask

  task automatic error_req(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
    drive(rd, wr, addr, data);
    #1;
    check("err_flag", 64'(bus.dmem_error), 64'd1);
    check("err_nostall", 64'(bus.mem_stall), 64'd0);
    check("err_nodone", 64'(bus.mem_done), 64'd0);
    @(negedge clk);
    #1;
    check("err_held", 64'(bus.dmem_error), 64'd1);
    check("err_held_nostall", 64'(bus.mem_stall), 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    check("err_clear", 64'(bus.dmem_error), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    bus1.mem_read = 1'b0; bus1.mem_write = 1'b0;
    bus1.mem_addr = 64'd0; bus1.mem_data = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_valM", bus.m_valM, 64'd0);
    check("rst_stall", 64'(bus.mem_stall), 64'd0);
    check("rst_done", 64'(bus.mem_done), 64'd0);
    check("rst_err", 64'(bus.dmem_error), 64'd0);
    check("rst1_valM", bus1.m_valM, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read at address 16, then confirm m_valM holds while idle.
    do_access(1'b0, 1'b1, 64'd16, D1);
    go_idle();
    do_access(1'b1, 1'b0, 64'd16, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    check("valM_hold", bus.m_valM, D1);
    @(negedge clk);

    // Unaligned read spanning a word boundary.
    do_access(1'b0, 1'b1, 64'd24, 64'd0);
    do_access(1'b0, 1'b1, 64'd16, D1);
    go_idle();
`ifdef DMEM_ALIGN_CHECK_EN
    error_req(1'b1, 1'b0, 64'd17, 64'd0);
`else
    do_access(1'b1, 1'b0, 64'd17, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    check("unaligned_17", bus.m_valM, 64'h0011223344556677);
    @(negedge clk);
`endif

    // Top-of-memory access, back-to-back with its readback.
    do_access(1'b0, 1'b1, 64'd1016, D2);
    do_access(1'b1, 1'b0, 64'd1016, 64'd0);
    go_idle();
    error_req(1'b1, 1'b0, 64'd1017, 64'd0);
    error_req(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0);

    // Read/write conflict must not disturb memory.
    error_req(1'b1, 1'b1, 64'd16, 64'hAA);
    do_access(1'b1, 1'b0, 64'd16, 64'd0);
    go_idle();

    // Abort in WAIT: the store is discarded.
    do_access(1'b0, 1'b1, 64'd0, D3);
    go_idle();
    drive(1'b0, 1'b1, 64'd0, 64'd5);
    #1;
    check("abort_accept_stall", 64'(bus.mem_stall), 64'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    check("abort_nostall", 64'(bus.mem_stall), 64'd0);
    check("abort_nodone", 64'(bus.mem_done), 64'd0);
    @(negedge clk);
    #1;
    check("abort_idle_done", 64'(bus.mem_done), 64'd0);
    @(negedge clk);
    do_access(1'b1, 1'b0, 64'd0, 64'd0);
    go_idle();

    // Reset asserted in WAIT: outputs clear at once, store lost.
    drive(1'b0, 1'b1, 64'd0, 64'd5);
    #1;
    check("rstw_accept_stall", 64'(bus.mem_stall), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw_stall", 64'(bus.mem_stall), 64'd0);
    check("rstw_done", 64'(bus.mem_done), 64'd0);
    check("rstw_valM", bus.m_valM, 64'd0);
    check("rstw_err", 64'(bus.dmem_error), 64'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(1'b1, 1'b0, 64'd0, 64'd0);
    drive(1'b0, 1'b0, 64'd0, 64'd0);
    #1;
    check("rstw_old_value", bus.m_valM, D3);
    @(negedge clk);

    // Single-cycle instance: completion and data in the request cycle.
    bus1.mem_write = 1'b1; bus1.mem_addr = 64'd40; bus1.mem_data = D4;
    #1;
    check("l1_wr_done", 64'(bus1.mem_done), 64'd1);
    check("l1_wr_nostall", 64'(bus1.mem_stall), 64'd0);
    @(negedge clk);
    bus1.mem_write = 1'b0; bus1.mem_read = 1'b1;
    #1;
    check("l1_rd_done", 64'(bus1.mem_done), 64'd1);
    check("l1_rd_nostall", 64'(bus1.mem_stall), 64'd0);
    check("l1_rd_data", bus1.m_valM, D4);
    @(negedge clk);
    bus1.mem_read = 1'b0;
    #1;
    check("l1_hold", bus1.m_valM, D4);
    check("l1_idle_done", 64'(bus1.mem_done), 64'd0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
